data_memory: RTL
================

# data_memory

Parametrised byte-addressable data memory for the single-cycle RISC-V datapath, the successor to the word-only data memory. It supports byte/half/word stores with per-byte lane writes and sign- or zero-extended loads. It also flags misaligned accesses, offers an optional registered read port for future pipelined cores, and clears itself after reset with a counter-driven init state machine. It sits between the ALU result/rs2 path and the write-back mux.

## Interface
- DEPTH, 64: number of 32-bit words; power of two, ≥2.
- ADDR_WIDTH, $clog2(DEPTH)+2: byte-address width.
- READ_REG, 0: 0 = combinational read (same cycle); 1 = registered read (one cycle).
- INIT_CLEAR, 1: 1 = zero all words after reset before accepting requests; 0 = skip init.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; one clock, asynchronous, active-high.
- req_i  in  1  access request this cycle.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 half, 10 word; 11 reserved, treated as word.
- unsigned_i  in  1  load extension: 1 zero-extend, 0 sign-extend.
- addr_i  in  ADDR_WIDTH  byte address; word index addr_i[ADDR_WIDTH-1:2].
- wdata_i  in  32  store data, right-justified.
- rdata_o  out  32  extended load data.
- rvalid_o  out  1  rdata_o valid.
- ready_o  out  1  requests accepted this cycle.
- misaligned_o  out  1  accepted request is misaligned.
- init_done_o  out  1  init sequence complete, sticky until reset.

## Operation
- FSM states are INIT and IDLE.
- Reset enters INIT if INIT_CLEAR=1, otherwise IDLE.
- INIT:
  - Word counter runs 0..DEPTH-1 and writes zero to one word per cycle.
  - On the last word, go to IDLE and set init_done_o.
  - ready_o=0; req_i is ignored. The requester holds its request.
- IDLE: ready_o=1. An access is accepted when req_i & ready_o.
- Misaligned means half with addr_i[0]=1, or word with addr_i[1:0]≠0.
  - misaligned_o=1.
  - A misaligned store writes nothing. A misaligned load returns 0 with rvalid_o=1.
- Store lanes:
  - Byte writes lane addr_i[1:0] with wdata_i[7:0].
  - Half writes lanes {addr_i[1],0} and +1 with wdata_i[15:0].
  - Word writes all four lanes.
  - Lanes not written keep their value.
- Load: select the lanes by the same rule, then extend bit 7/15 per unsigned_i. Word loads are passed through unchanged.
- No accepted load means rdata_o=0 and rvalid_o=0.
- Reset asserted mid-INIT restarts INIT from word 0. Reset does not clear the array except through INIT.

## Timing
- Reset values:
  - ready_o=0 when INIT_CLEAR=1, else 1.
  - init_done_o=0 when INIT_CLEAR=1, else 1.
  - rdata_o=0, rvalid_o=0, misaligned_o=0.
- INIT lasts exactly DEPTH cycles after rst_i deasserts. ready_o rises on cycle DEPTH.
- Stores commit on the rising edge that accepts them.
- Loads with READ_REG=0: rdata_o, rvalid_o and misaligned_o are combinational in the acceptance cycle.
- Loads with READ_REG=1:
  - rdata_o, rvalid_o and misaligned_o are registered and appear one cycle after acceptance.
  - They return to 0 the next cycle unless another load is accepted.
  - Back-to-back loads give one result per cycle.
- Stores with READ_REG=1 register misaligned_o the same way, with rvalid_o=0.
- A store followed by a load to the same word in the next cycle returns the new data.
- Only one access happens per cycle, so there is no read/write collision.

## Structure
- Package dmem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD localparams.
  - The state enum {ST_INIT, ST_IDLE}.
  - The misalignment-check function.
- Sub-module dmem_lane_align is purely combinational. It produces the store byte-enable and shifted write data, and the load lane extract plus sign/zero extension. It is shared so the write-back path can reuse it.
- Top level holds the FSM, init counter, array (byte-enable write) and optional read register.

## Test plan
- Reset, DEPTH=64, INIT_CLEAR=1: ready_o low for 64 cycles, then high with init_done_o=1. A load from word 63 returns 0.
- Store word 0xDEADBEEF @0x10, then byte 0x5A @0x12: load word @0x10 gives 0xDE5ABEEF. Load byte signed @0x13 gives 0xFFFFFFDE. Load byte unsigned @0x13 gives 0x000000DE.
- Store half 0x8001 @0x22: load half signed @0x22 gives 0xFFFF8001, unsigned gives 0x00008001. Upper half of the word is unchanged.
- Store word 0x12345678 @0x31 (misaligned): misaligned_o=1. A word load @0x30 still returns its prior value. A half load @0x05 returns 0 with misaligned_o=1.
- READ_REG=1: loads @0x10, @0x14, @0x18 on consecutive cycles return data one cycle later, back-to-back, with rvalid_o high for 3 cycles.
- rst_i pulsed at INIT cycle 30: the counter restarts, and ready_o rises 64 cycles after deassertion.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the byte-addressable data memory:
//   - access size encodings driven on size_i (11 is reserved and behaves as word)
//   - controller state encoding (clear-after-reset vs. serving requests)
//   - the alignment rule shared by the store and load paths
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic {
      ST_INIT,
      ST_IDLE
   } dmem_state_e;

   // A half must sit on an even byte address and a word on a multiple of four.
   // Any encoding other than byte or half, including the reserved one, counts
   // as a word.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] byte_off);
      logic mis;
      case (size)
         SIZE_BYTE: mis = 1'b0;
         SIZE_HALF: mis = byte_off[0];
         default:   mis = |byte_off;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational lane steering for 32-bit little-endian memory words.
// The same block can be reused by the write-back path.
//
// Ports:
//   size_i      access size (byte / half / word, reserved = word)
//   unsigned_i  load extension: 1 zero-extend, 0 sign-extend
//   byte_off_i  byte address bits [1:0]
//   wdata_i     right-justified store data
//   rword_i     full memory word being loaded
//   be_o        byte enables for the store
//   wdata_o     store data replicated onto every lane (be_o picks the lanes)
//   rdata_o     extracted and extended load data
// -----------------------------------------------------------------------------
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [1:0]  byte_off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // Lane extraction for loads. A half only ever looks at bit 1 of the
   // offset; misaligned halves are masked off by the caller.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path can leave it unassigned and infer a latch.
      rbyte = rword_i[7:0];
      case (byte_off_i)
         2'd0:    rbyte = rword_i[7:0];
         2'd1:    rbyte = rword_i[15:8];
         2'd2:    rbyte = rword_i[23:16];
         default: rbyte = rword_i[31:24];
      endcase
      rhalf = byte_off_i[1] ? rword_i[31:16] : rword_i[15:0];
   end

   always_comb begin
      be_o    = 4'b0000;
      wdata_o = 32'd0;
      rdata_o = 32'd0;
      case (size_i)
         SIZE_BYTE: begin
            be_o    = 4'b0001 << byte_off_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{~unsigned_i & rbyte[7]}}, rbyte};
         end
         SIZE_HALF: begin
            be_o    = byte_off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {{16{~unsigned_i & rhalf[15]}}, rhalf};
         end
         default: begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
            rdata_o = rword_i;
         end
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// Byte-addressable data memory for the single-cycle RISC-V datapath.
// Byte/half/word stores with per-lane writes, sign/zero-extended loads,
// misalignment flagging, optional registered read port and a clear-after-reset
// sequence that zeroes one word per cycle.
//
// Parameters:
//   DEPTH       number of 32-bit words (power of two, >= 2)
//   ADDR_WIDTH  byte address width
//   READ_REG    0 = results in the acceptance cycle, 1 = one cycle later
//   INIT_CLEAR  1 = zero the array after reset before serving requests
//
// Ports:
//   clk_i, rst_i   clock (rising edge), asynchronous active-high reset
//   req_i, we_i    access request, 1 = store / 0 = load
//   size_i         00 byte, 01 half, 10/11 word
//   unsigned_i     load extension select
//   addr_i         byte address, word index addr_i[ADDR_WIDTH-1:2]
//   wdata_i        right-justified store data
//   rdata_o        extended load data (0 when no valid load)
//   rvalid_o       rdata_o valid
//   ready_o        requests are accepted this cycle
//   misaligned_o   accepted request is misaligned
//   init_done_o    clear sequence finished, sticky until reset
// -----------------------------------------------------------------------------
module data_memory
   import dmem_pkg::*;
#(
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH) + 2,
   parameter int READ_REG   = 0,
   parameter int INIT_CLEAR = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_i,
   input  logic                  we_i,
   input  logic [1:0]            size_i,
   input  logic                  unsigned_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o,
   output logic                  rvalid_o,
   output logic                  ready_o,
   output logic                  misaligned_o,
   output logic                  init_done_o
);

   localparam int               IDX_W     = ADDR_WIDTH - 2;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
   localparam dmem_state_e      RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
   localparam logic             RST_DONE  = (INIT_CLEAR == 0);

   dmem_state_e      state_q, state_d;
   logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
   logic             init_done_q, init_done_d;

   logic [31:0]      mem [DEPTH];

   logic [1:0]       byte_off;
   logic [IDX_W-1:0] word_idx;
   logic [31:0]      rd_word;
   logic             misaligned;

   logic [3:0]       lane_be;
   logic [31:0]      lane_wdata;
   logic [31:0]      lane_rdata;

   logic             ready;
   logic             accept;
   logic             load_acc;
   logic             store_acc;

   logic             mem_we;
   logic [IDX_W-1:0] mem_widx;
   logic [3:0]       mem_be;
   logic [31:0]      mem_wdata;

   logic [31:0]      rdata_d;
   logic             rvalid_d;
   logic             misaligned_d;

   assign byte_off   = addr_i[1:0];
   assign word_idx   = addr_i[ADDR_WIDTH-1:2];
   assign rd_word    = mem[word_idx];
   assign misaligned = is_misaligned(size_i, byte_off);

   dmem_lane_align u_lane_align (
      .size_i     (size_i),
      .unsigned_i (unsigned_i),
      .byte_off_i (byte_off),
      .wdata_i    (wdata_i),
      .rword_i    (rd_word),
      .be_o       (lane_be),
      .wdata_o    (lane_wdata),
      .rdata_o    (lane_rdata)
   );

   // ---------------------------------------------------------------------------
   // Controller state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: flops take non-blocking assignments so every register samples
      // the values from before the edge, regardless of statement order.
      if (rst_i) begin
         state_q     <= RST_STATE;
         init_cnt_q  <= '0;
         init_done_q <= RST_DONE;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic: INIT walks the word counter once, then parks in IDLE.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_IDX) begin
               state_d     = ST_IDLE;
               init_cnt_d  = '0;
               init_done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output / datapath control
   // ---------------------------------------------------------------------------
   always_comb begin
      ready     = (state_q == ST_IDLE);
      accept    = req_i & ready;
      load_acc  = accept & ~we_i;
      store_acc = accept & we_i & ~misaligned;

      // A misaligned load still completes, but with zero data.
      rdata_d      = (load_acc & ~misaligned) ? lane_rdata : 32'd0;
      rvalid_d     = load_acc;
      misaligned_d = accept & misaligned;

      // The single write port is owned by the clear sequence during INIT and
      // by accepted aligned stores afterwards. No writes while reset is held.
      mem_we    = 1'b0;
      mem_widx  = word_idx;
      mem_be    = lane_be;
      mem_wdata = lane_wdata;
      if (state_q == ST_INIT) begin
         mem_we    = ~rst_i;
         mem_widx  = init_cnt_q;
         mem_be    = 4'b1111;
         mem_wdata = 32'd0;
      end else if (store_acc) begin
         mem_we    = ~rst_i;
      end
   end

   assign ready_o     = ready;
   assign init_done_o = init_done_q;

   // ---------------------------------------------------------------------------
   // Storage array with per-byte write enables
   // ---------------------------------------------------------------------------
   // NOTE: the array is deliberately not reset; resetting it would turn it into
   // DEPTH*32 flops. Contents are cleared only by the INIT sequence.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) begin
               mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Result port: direct or one-cycle registered
   // ---------------------------------------------------------------------------
   generate
      if (READ_REG != 0) begin : g_read_reg
         logic [31:0] rdata_q;
         logic        rvalid_q;
         logic        misaligned_q;

         // Registering the already-gated values makes the outputs fall back to
         // zero on the cycle after the last accepted access.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               rdata_q      <= 32'd0;
               rvalid_q     <= 1'b0;
               misaligned_q <= 1'b0;
            end else begin
               rdata_q      <= rdata_d;
               rvalid_q     <= rvalid_d;
               misaligned_q <= misaligned_d;
            end
         end

         assign rdata_o      = rdata_q;
         assign rvalid_o     = rvalid_q;
         assign misaligned_o = misaligned_q;
      end else begin : g_read_comb
         assign rdata_o      = rdata_d;
         assign rvalid_o     = rvalid_d;
         assign misaligned_o = misaligned_d;
      end
   endgenerate

endmodule
